loctag_adc_sampler: RTL
=======================

LOCTAG_ADC_SAMPLER -- requirements
Module: loctag_adc_sampler

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per adc_clk half-period (adc_clk = clk/(2*CLK_DIV)); legal range 1..255.
REQ-002 Parameter SETTLE_CYCLES, default 1000: clk cycles between lt5534_en rising and the first conversion.
REQ-003 Parameter QUIET_CYCLES, default 2: minimum adc_cs high time between frames, in clk cycles; legal minimum 1.
REQ-004 clk  input  1  system clock from the PLL, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  request continuous sampling; level-sensitive.
REQ-007 lt5534_en  output  1  detector power enable.
REQ-008 adc_cs  output  1  ADC chip select, active low.
REQ-009 adc_clk  output  1  ADC serial clock, idles high.
REQ-010 adc_so  input  1  ADC serial data, MSB first, changes after adc_clk falling edge.
REQ-011 sample  output  8  last converted value.
REQ-012 sample_avg  output  8  averaged value (see Configuration).
REQ-013 sample_valid  output  1  one-cycle strobe, sample/sample_avg updated this cycle.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, SETTLE, QUIET, SHIFT, DONE.
REQ-016 IDLE: lt5534_en=0, adc_cs=1, adc_clk=1; enable=1 -> SETTLE next cycle, lt5534_en=1.
REQ-017 SETTLE: lt5534_en=1; after SETTLE_CYCLES clk cycles -> QUIET; enable=0 during SETTLE -> IDLE next cycle.
REQ-018 QUIET: adc_cs=1 for QUIET_CYCLES cycles -> SHIFT.
REQ-019 SHIFT: adc_cs=0; adc_clk toggles every CLK_DIV cycles, first edge falling, CLK_DIV cycles after adc_cs falls; exactly 16 falling and 16 rising edges per frame.
REQ-020 adc_so is captured in the clk cycle that drives each adc_clk rising edge; rising edges numbered 0..15.
REQ-021 Bits 0..2 (leading zeros) and 11..15 (trailing) are discarded; bits 3..10 form sample[7:0], MSB first; nonzero discarded bits have no effect.
REQ-022 After rising edge 15 -> DONE: adc_cs=1, adc_clk=1, sample and sample_avg updated, sample_valid=1 for exactly that one cycle.
REQ-023 DONE -> QUIET if enable=1, else IDLE with lt5534_en=0 in the following cycle.
REQ-024 enable falling during QUIET or SHIFT does not abort; the current frame completes and is delivered.
REQ-025 Frame period with defaults: 2 + 64 + 1 = 67 clk cycles per sample_valid.
REQ-026 sample/sample_avg hold their value between strobes; never glitch outside DONE.

Reset
REQ-027 Reset asserted: FSM=IDLE, lt5534_en=0, adc_cs=1, adc_clk=1, sample=0, sample_avg=0, sample_valid=0, busy=0, all counters 0.
REQ-028 Reset mid-frame: outputs go to reset values immediately and without a clock edge; partial data discarded; no sample_valid issued.
REQ-029 After release, first SHIFT needs enable=1 plus the full SETTLE_CYCLES.

Configuration
REQ-030 Macro LOCTAG_ADC_AVG_EN defined: sample_avg = (sum of last 4 samples) >> 2, using a 10-bit sum; the history clears on reset and on entry to SETTLE; until 4 samples are collected, missing entries count as 0.
REQ-031 Macro undefined: no history registers; sample_avg equals sample on every cycle.

Structure
REQ-032 Package loctag_pkg: FSM state enum, ADC frame constants (FRAME_BITS=16, LEAD_BITS=3, DATA_BITS=8).
REQ-033 One sub-module, loctag_clk_en: CLK_DIV half-period tick generator, cleared whenever adc_cs is high.

Verification
REQ-034 ADC model returns 0xA5 with enable=1 -> sample=0xA5 and one sample_valid; 16 adc_clk rising edges while adc_cs=0.
REQ-035 Defaults, enable held -> first sample_valid 1000+2+64+1 cycles after enable; strobes every 67 cycles thereafter.
REQ-036 enable dropped at adc_clk rising edge 5 -> frame completes with a valid value; next cycle IDLE, lt5534_en=0.
REQ-037 Reset pulse at rising edge 8 -> adc_cs=1 and adc_clk=1 immediately; no sample_valid; sample=0.
REQ-038 LOCTAG_ADC_AVG_EN defined, samples 0x10,0x20,0x30,0x40 -> sample_avg=0x04,0x0C,0x18,0x28; macro undefined -> sample_avg tracks sample.
REQ-039 Leading and trailing bits driven to 1 with data 0x00 -> sample=0x00.

Source files
------------

// File: rtl/loctag_pkg.sv
// Shared definitions for the LT5534 detector ADC sampler: FSM states,
// ADC frame geometry and a helper that picks the data bits out of a frame.
package loctag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_QUIET,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 3;
  localparam int DATA_BITS  = 8;

  typedef logic [3:0] bit_idx_t;

  localparam bit_idx_t FIRST_DATA_IDX = 4'(LEAD_BITS);
  localparam bit_idx_t LAST_DATA_IDX  = 4'(LEAD_BITS + DATA_BITS - 1);
  localparam bit_idx_t LAST_BIT_IDX   = 4'(FRAME_BITS - 1);

  // True for the rising-edge indices that carry conversion data.
  function automatic logic is_data_bit(input bit_idx_t idx);
    return (idx >= FIRST_DATA_IDX) && (idx <= LAST_DATA_IDX);
  endfunction

endpackage

// File: rtl/loctag_clk_en.sv
// Half-period tick generator for the ADC serial clock. Produces a one-cycle
// tick every CLK_DIV clk cycles while clear_i is low; held at zero otherwise,
// so the first tick always lands CLK_DIV cycles after chip select falls.
module loctag_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clear_i && (cnt_q == LAST);

  // Count clk cycles inside a half-period, restarting after each tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/loctag_adc_sampler.sv
// LT5534 detector power control plus 16-bit serial ADC frame reader.
// Powers the detector, waits for it to settle, then reads frames back to back
// while enable is high, extracting the 8 data bits of each frame.
// Optional feature: define LOCTAG_ADC_AVG_EN to make sample_avg a running
// mean of the last four samples; otherwise sample_avg mirrors sample.
module loctag_adc_sampler
  import loctag_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SETTLE_CYCLES = 1000,
  parameter int QUIET_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       lt5534_en,
  output logic       adc_cs,
  output logic       adc_clk,
  input  logic       adc_so,
  output logic [7:0] sample,
  output logic [7:0] sample_avg,
  output logic       sample_valid,
  output logic       busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > QUIET_CYCLES) ? SETTLE_CYCLES : QUIET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  bit_idx_t               bit_q, bit_d;
  logic                   adc_clk_q, adc_clk_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [7:0]             sample_q, sample_d;
  logic                   tick;
  logic                   frame_done;

  // Outputs decode straight from registered state so reset reaches them
  // without waiting for a clock edge.
  assign lt5534_en    = (state_q != ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign adc_cs       = (state_q != ST_SHIFT);
  assign adc_clk      = adc_clk_q;
  assign sample_valid = (state_q == ST_DONE);
  assign sample       = sample_q;

  loctag_clk_en #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_en (
    .clk    (clk),
    .reset  (reset),
    .clear_i(adc_cs),
    .tick_o (tick)
  );

  // Next-state logic: detector settle, inter-frame quiet time and the
  // 16-edge serial shift, capturing data on each adc_clk rising edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    adc_clk_d = 1'b1;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_QUIET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_QUIET: begin
        bit_d = '0;
        if (cnt_q == QUIET_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        adc_clk_d = adc_clk_q;
        if (tick) begin
          adc_clk_d = ~adc_clk_q;
          if (!adc_clk_q) begin
            if (is_data_bit(bit_q)) begin
              shift_d = {shift_q[DATA_BITS-2:0], adc_so};
            end
            if (bit_q == LAST_BIT_IDX) begin
              state_d = ST_DONE;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = enable ? ST_QUIET : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign frame_done = (state_q == ST_SHIFT) && (state_d == ST_DONE);

  // The delivered sample only changes on the edge that enters DONE.
  always_comb begin
    sample_d = sample_q;
    if (frame_done) begin
      sample_d = shift_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      adc_clk_q <= 1'b1;
      shift_q   <= '0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      adc_clk_q <= adc_clk_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
    end
  end

`ifdef LOCTAG_ADC_AVG_EN
  logic [2:0][7:0] hist_q, hist_d;
  logic [7:0]      avg_q, avg_d;
  logic [9:0]      avg_sum;
  logic            settle_entry;

  assign settle_entry = (state_q == ST_IDLE) && (state_d == ST_SETTLE);
  assign sample_avg   = avg_q;

  // Mean of the new sample and the three before it; history restarts empty
  // each time the detector is powered up.
  always_comb begin
    hist_d  = hist_q;
    avg_d   = avg_q;
    avg_sum = {2'b00, shift_q} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    if (settle_entry) begin
      hist_d = '0;
    end else if (frame_done) begin
      hist_d = {hist_q[1:0], shift_q};
      avg_d  = avg_sum[9:2];
    end
  end

  // Averaging history and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      avg_q  <= '0;
    end else begin
      hist_q <= hist_d;
      avg_q  <= avg_d;
    end
  end
`else
  assign sample_avg = sample_q;
`endif

endmodule
